// File: rtl/ib_endpoint_slave_mem_pkg.sv
// Shared types and helpers for the IB endpoint slave memory target.
package ib_endpoint_slave_mem_pkg;

    localparam int DATA_W  = 64;
    localparam int BE_W    = 8;
    localparam int LEN_W   = 12;
    localparam int BEATS_W = 13;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [BE_W-1:0]    be_t;
    typedef logic [LEN_W-1:0]   len_t;
    typedef logic [BEATS_W-1:0] beats_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } pipe_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_FRAME
    } wr_state_t;

    // Beats spanned by a frame of len bytes starting at byte offset addr_lo; len 0 means 4096.
    function automatic beats_t exp_beats(input len_t len, input logic [2:0] addr_lo);
        beats_t total;
        total = (len == '0) ? beats_t'(4096) : beats_t'(len);
        total = total + beats_t'(addr_lo) + beats_t'(7);
        return total >> 3;
    endfunction

endpackage

// File: rtl/ib_endpoint_slave_mem_if.sv
// User-side write/read bus between the IB endpoint (master) and the slave memory (slave).
interface ib_endpoint_slave_mem_if;
    import ib_endpoint_slave_mem_pkg::*;

    logic [31:0] wr_addr;
    word_t       wr_data;
    be_t         wr_be;
    logic        wr_req;
    logic        wr_rdy;
    len_t        wr_length;
    logic        wr_sof;
    logic        wr_eof;

    logic [31:0] rd_addr;
    be_t         rd_be;
    logic        rd_req;
    logic        rd_ardy;
    logic        rd_sof_in;
    logic        rd_eof_in;
    word_t       rd_data;
    logic        rd_src_rdy;
    logic        rd_dst_rdy;

    logic        err;

    modport master (
        output wr_addr, wr_data, wr_be, wr_req, wr_length, wr_sof, wr_eof,
        output rd_addr, rd_be, rd_req, rd_sof_in, rd_eof_in, rd_dst_rdy,
        input  wr_rdy, rd_ardy, rd_data, rd_src_rdy, err
    );

    modport slave (
        input  wr_addr, wr_data, wr_be, wr_req, wr_length, wr_sof, wr_eof,
        input  rd_addr, rd_be, rd_req, rd_sof_in, rd_eof_in, rd_dst_rdy,
        output wr_rdy, rd_ardy, rd_data, rd_src_rdy, err
    );

endinterface

// File: rtl/ib_endpoint_slave_mem_rdbuf.sv
// Read output buffer with outstanding-request accounting; admits a read only when its slot is guaranteed.
module ib_endpoint_slave_mem_rdbuf
    import ib_endpoint_slave_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  run,
    input  logic  accept,
    input  logic  in_valid,
    input  word_t in_data,
    input  logic  dst_rdy,
    output logic  ardy,
    output logic  src_rdy,
    output word_t data
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    word_t buf_mem [DEPTH];
    ptr_t  wr_ptr_reg;
    ptr_t  rd_ptr_reg;
    cnt_t  out_cnt_reg;
    cnt_t  buf_cnt_reg;
    logic  pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign src_rdy = (buf_cnt_reg != '0);
    assign pop     = src_rdy & dst_rdy;
    assign data    = src_rdy ? buf_mem[rd_ptr_reg] : '0;
    // Counting in-pipe reads as well as buffered ones is what makes overflow impossible.
    assign ardy    = run & (out_cnt_reg < cnt_t'(DEPTH));

    always_ff @(posedge clk) begin
        if (in_valid) begin
            buf_mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            out_cnt_reg <= '0;
            buf_cnt_reg <= '0;
        end else begin
            if (in_valid) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({accept, pop})
                2'b10:   out_cnt_reg <= out_cnt_reg + cnt_t'(1);
                2'b01:   out_cnt_reg <= out_cnt_reg - cnt_t'(1);
                default: ;
            endcase
            case ({in_valid, pop})
                2'b10:   buf_cnt_reg <= buf_cnt_reg + cnt_t'(1);
                2'b01:   buf_cnt_reg <= buf_cnt_reg - cnt_t'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ib_endpoint_slave_mem.sv
// Byte-addressable 64-bit slave memory behind the IB endpoint, with write-frame checking.
// Define IB_ENDPOINT_SLAVE_MEM_THROTTLE_EN to gate the ready outputs with an LFSR.
module ib_endpoint_slave_mem
    import ib_endpoint_slave_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          READ_LATENCY = 2,
    parameter int          OUT_DEPTH    = READ_LATENCY + 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    ib_endpoint_slave_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] idx_t;

    logic        run_reg;
    logic        wr_gate;
    logic        rd_gate;
    logic        ardy_raw;
    logic        wr_fire;
    logic        rd_fire;
    idx_t        widx;
    idx_t        ridx;
    logic        v0_reg;
    be_t         byp_mask_reg;
    word_t       byp_data_reg;
    word_t       merged0;
    pipe_entry_t stage_out [READ_LATENCY];
    wr_state_t   state_reg;
    beats_t      exp_reg;
    beats_t      beat_cnt_reg;
    beats_t      beat_cnt_next;
    beats_t      sof_exp;
    logic        err_reg;

    assign widx    = bus.wr_addr[ADDR_WIDTH+2:3];
    assign ridx    = bus.rd_addr[ADDR_WIDTH+2:3];
    assign wr_fire = bus.wr_req & bus.wr_rdy;
    assign rd_fire = bus.rd_req & bus.rd_ardy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

`ifdef IB_ENDPOINT_SLAVE_MEM_THROTTLE_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign wr_gate = lfsr_reg[0];
    assign rd_gate = lfsr_reg[5];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign wr_gate     = 1'b1;
    assign rd_gate     = 1'b1;
`endif

    assign bus.wr_rdy  = run_reg & wr_gate;
    assign bus.rd_ardy = ardy_raw & rd_gate;

    // One RAM per byte lane so byte enables map onto plain lane write enables.
    genvar gi;
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q_reg;

        always_ff @(posedge clk) begin
            if (wr_fire && bus.wr_be[gi]) begin
                lane_mem[widx] <= bus.wr_data[gi*8 +: 8];
            end
            if (rd_fire) begin
                lane_q_reg <= lane_mem[ridx];
            end
        end

        assign merged0[gi*8 +: 8] = byp_mask_reg[gi] ? byp_data_reg[gi*8 +: 8] : lane_q_reg;
    end

    // The RAM read returns pre-write data, so same-word, same-cycle writes are overlaid here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_reg       <= 1'b0;
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
        end else begin
            v0_reg       <= rd_fire;
            byp_mask_reg <= (rd_fire && wr_fire && (widx == ridx)) ? bus.wr_be : '0;
            byp_data_reg <= bus.wr_data;
        end
    end

    assign stage_out[0] = '{valid: v0_reg, data: merged0};

    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
        pipe_entry_t stage_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg <= '0;
            end else begin
                stage_reg <= stage_out[gi-1];
            end
        end

        assign stage_out[gi] = stage_reg;
    end

    ib_endpoint_slave_mem_rdbuf #(
        .DEPTH (OUT_DEPTH)
    ) u_rdbuf (
        .clk      (clk),
        .rst      (rst),
        .run      (run_reg),
        .accept   (rd_fire),
        .in_valid (stage_out[READ_LATENCY-1].valid),
        .in_data  (stage_out[READ_LATENCY-1].data),
        .dst_rdy  (bus.rd_dst_rdy),
        .ardy     (ardy_raw),
        .src_rdy  (bus.rd_src_rdy),
        .data     (bus.rd_data)
    );

    assign sof_exp       = exp_beats(bus.wr_length, bus.wr_addr[2:0]);
    assign beat_cnt_next = beat_cnt_reg + beats_t'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            exp_reg      <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (wr_fire) begin
            if (bus.wr_sof) begin
                if (state_reg == ST_IN_FRAME) begin
                    err_reg <= 1'b1;
                end
                if (bus.wr_eof) begin
                    if (sof_exp != beats_t'(1)) begin
                        err_reg <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg    <= ST_IN_FRAME;
                    exp_reg      <= sof_exp;
                    beat_cnt_reg <= beats_t'(1);
                end
            end else if (state_reg == ST_IDLE) begin
                err_reg <= 1'b1;
            end else begin
                beat_cnt_reg <= beat_cnt_next;
                if (bus.wr_eof) begin
                    if (beat_cnt_next != exp_reg) begin
                        err_reg <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

    assign bus.err = err_reg;

    logic unused;
    assign unused = &{1'b0, bus.rd_be, bus.rd_sof_in, bus.rd_eof_in, bus.wr_addr, bus.rd_addr};

endmodule

// File: tb/tb_ib_endpoint_slave_mem.sv
// Self-checking bench for ib_endpoint_slave_mem: frame-error table, directed corner cases, random traffic vs a memory model.
module tb_ib_endpoint_slave_mem;
    import ib_endpoint_slave_mem_pkg::*;

    localparam int ADDR_WIDTH   = 10;
    localparam int READ_LATENCY = 2;
    localparam int OUT_DEPTH    = READ_LATENCY + 2;
    localparam int MEM_WORDS    = 1 << ADDR_WIDTH;

    typedef struct {
        logic [31:0] addr;
        logic [11:0] len;
        int          beats;
        int          kind;     // 0 normal, 1 stray non-SOF beat, 2 second SOF on beat 1
        logic        exp_err;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ib_endpoint_slave_mem_if bus ();

    ib_endpoint_slave_mem #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .READ_LATENCY (READ_LATENCY),
        .OUT_DEPTH    (OUT_DEPTH),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          fails  = 0;
    logic [63:0] mdl_mem [MEM_WORDS];
    logic [63:0] exp_q [$];
    frame_vec_t  vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0; bus.wr_req = 1'b0;
        bus.wr_length = '0; bus.wr_sof = 1'b0; bus.wr_eof = 1'b0;
        bus.rd_addr = '0; bus.rd_be = '0; bus.rd_req = 1'b0;
        bus.rd_sof_in = 1'b0; bus.rd_eof_in = 1'b0; bus.rd_dst_rdy = 1'b1;
    endtask

    // One clock: evaluate handshakes, update the model, compare popped data, advance.
    task automatic tick();
        logic        wacc, racc, pop;
        logic [63:0] pdata;
        int          widx;
        #1;
        wacc  = bus.wr_req && bus.wr_rdy;
        racc  = bus.rd_req && bus.rd_ardy;
        pop   = bus.rd_src_rdy && bus.rd_dst_rdy;
        pdata = bus.rd_data;
        if (wacc) begin
            widx = int'((bus.wr_addr >> 3) % MEM_WORDS);
            for (int b = 0; b < 8; b++)
                if (bus.wr_be[b]) mdl_mem[widx][8*b +: 8] = bus.wr_data[8*b +: 8];
        end
        if (racc) exp_q.push_back(mdl_mem[int'((bus.rd_addr >> 3) % MEM_WORDS)]);
        if (pop) begin
            check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("rd_data_order", pdata, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_src_rdy", 64'(bus.rd_src_rdy), 64'd0);
        check("rst_rd_ardy", 64'(bus.rd_ardy), 64'd0);
        check("rst_wr_rdy", 64'(bus.wr_rdy), 64'd0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_rd_ardy", 64'(bus.rd_ardy), 64'd1);
        check("post_rst_wr_rdy", 64'(bus.wr_rdy), 64'd1);
    endtask

    task automatic wr_single(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] be);
        bus.wr_addr = addr; bus.wr_data = data; bus.wr_be = be; bus.wr_length = 12'd8;
        bus.wr_sof = 1'b1; bus.wr_eof = 1'b1; bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
    endtask

    task automatic wait_src(input string name);
        int n = 0;
        while (!bus.rd_src_rdy && n < 20) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 64'(bus.rd_src_rdy), 64'd1);
    endtask

    task automatic read_expect(input string name, input logic [31:0] addr, input logic [63:0] exp);
        bus.rd_addr = addr; bus.rd_req = 1'b1; bus.rd_dst_rdy = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        wait_src(name);
        check(name, bus.rd_data, exp);
        tick();
    endtask

    initial begin
        int acc;

        vecs[0]  = '{32'h10, 12'd8,    1,   0, 1'b0};
        vecs[1]  = '{32'h04, 12'd16,   2,   0, 1'b1};
        vecs[2]  = '{32'h04, 12'd16,   3,   0, 1'b0};
        vecs[3]  = '{32'h00, 12'd0,    512, 0, 1'b0};
        vecs[4]  = '{32'h01, 12'd0,    512, 0, 1'b1};
        vecs[5]  = '{32'h00, 12'd8,    2,   0, 1'b1};
        vecs[6]  = '{32'h07, 12'd2,    2,   0, 1'b0};
        vecs[7]  = '{32'h00, 12'd17,   3,   0, 1'b0};
        vecs[8]  = '{32'h00, 12'd8,    1,   1, 1'b1};
        vecs[9]  = '{32'h00, 12'd24,   3,   2, 1'b1};
        vecs[10] = '{32'h03, 12'd4095, 513, 0, 1'b0};

        idle();
        #1;
        do_reset();

        for (int w = 0; w < 16; w++) wr_single(32'(8 * w), {$urandom(), $urandom()}, 8'hFF);

        // Read latency: data appears exactly READ_LATENCY edges after the accept edge.
        wr_single(32'h10, 64'h1122334455667788, 8'hFF);
        bus.rd_addr = 32'h10; bus.rd_req = 1'b1; bus.rd_dst_rdy = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        for (int n = 0; n <= READ_LATENCY; n++) begin
            check($sformatf("lat_src_rdy_%0d", n), 64'(bus.rd_src_rdy), 64'(n == READ_LATENCY));
            if (n == READ_LATENCY) check("lat_data", bus.rd_data, 64'h1122334455667788);
            tick();
        end
        check("lat_err", 64'(bus.err), 64'd0);

        wr_single(32'h0, 64'h0123456789ABCDEF, 8'hFF);
        wr_single(32'h0, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        read_expect("partial_be", 32'h0, 64'h01234567FFFFFFFF);

        // Backpressure: accepts stop at OUT_DEPTH, then drain in order.
        bus.rd_dst_rdy = 1'b0; bus.rd_req = 1'b1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            bus.rd_addr = 32'(8 * (1 + acc));
            if (bus.rd_ardy) acc++;
            tick();
        end
        check("bp_accepts", 64'(acc), 64'(OUT_DEPTH));
        check("bp_ardy_low", 64'(bus.rd_ardy), 64'd0);
        bus.rd_req = 1'b0; bus.rd_dst_rdy = 1'b1;
        repeat (OUT_DEPTH + 4) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_no_dup", 64'(bus.rd_src_rdy), 64'd0);

        wr_single(32'h28, 64'h5555555555555555, 8'hFF);
        bus.wr_addr = 32'h28; bus.wr_data = 64'hAAAAAAAAAAAAAAAA; bus.wr_be = 8'hFF;
        bus.wr_length = 12'd8; bus.wr_sof = 1'b1; bus.wr_eof = 1'b1; bus.wr_req = 1'b1;
        bus.rd_addr = 32'h28; bus.rd_req = 1'b1; bus.rd_dst_rdy = 1'b1;
        tick();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        wait_src("rdw");
        check("rdw_data", bus.rd_data, 64'hAAAAAAAAAAAAAAAA);
        tick();

        for (int v = 0; v < 11; v++) begin
            do_reset();
            for (int b = 0; b < vecs[v].beats; b++) begin
                bus.wr_addr   = vecs[v].addr + 32'(8 * b);
                bus.wr_data   = {$urandom(), $urandom()};
                bus.wr_be     = 8'hFF;
                bus.wr_length = vecs[v].len;
                bus.wr_sof    = (vecs[v].kind != 1) && (b == 0 || (vecs[v].kind == 2 && b == 1));
                bus.wr_eof    = (b == vecs[v].beats - 1);
                bus.wr_req    = 1'b1;
                tick();
            end
            bus.wr_req = 1'b0;
            tick();
            check($sformatf("frame_err_%0d", v), 64'(bus.err), 64'(vecs[v].exp_err));
        end

        // Random single-beat writes and reads over 16 aliased words with random backpressure.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.wr_req     = ($urandom_range(0, 1) == 1);
            bus.wr_addr    = ($urandom() & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 3);
            bus.wr_data    = {$urandom(), $urandom()};
            bus.wr_be      = 8'($urandom());
            bus.wr_length  = 12'($urandom_range(1, 8));
            bus.wr_sof     = 1'b1;
            bus.wr_eof     = 1'b1;
            bus.rd_req     = ($urandom_range(0, 1) == 1);
            bus.rd_addr    = ($urandom() & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 3)
                             | 32'($urandom_range(0, 7));
            bus.rd_be      = 8'($urandom());
            bus.rd_sof_in  = 1'($urandom_range(0, 1));
            bus.rd_eof_in  = 1'($urandom_range(0, 1));
            bus.rd_dst_rdy = ($urandom_range(0, 3) != 0);
            check("rnd_rd_ardy", 64'(bus.rd_ardy), 64'(exp_q.size() < OUT_DEPTH));
            tick();
        end
        idle();
        repeat (OUT_DEPTH + 6) tick();
        check("rnd_drained", 64'(exp_q.size()), 64'd0);
        check("rnd_err", 64'(bus.err), 64'd0);

        // Reset with a partial frame open and three reads in flight.
        bus.wr_addr = 32'h40; bus.wr_data = 64'hDEADBEEFCAFEF00D; bus.wr_be = 8'hFF;
        bus.wr_length = 12'd16; bus.wr_sof = 1'b1; bus.wr_eof = 1'b0; bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
        bus.rd_dst_rdy = 1'b0; bus.rd_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            bus.rd_addr = 32'(8 * r);
            tick();
        end
        bus.rd_req = 1'b0;
        check("pre_rst_src_rdy", 64'(bus.rd_src_rdy), 64'd1);
        do_reset();
        bus.rd_dst_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("no_stale_src_rdy", 64'(bus.rd_src_rdy), 64'd0);
            tick();
        end
        wr_single(32'h48, 64'h0102030405060708, 8'hFF);
        tick();
        check("frame_dropped_err", 64'(bus.err), 64'd0);
        read_expect("ram_kept", 32'h40, 64'hDEADBEEFCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
